pipe_hazard_ctrl: RTL

Central stall/flush/halt sequencer for the five-stage pipeline. Drives the write-enable (`en_w_or_r`) inputs of the PC and every inter-stage register bank (IF/ID, ID/EX, EX/MEM, MEM/WB). Generates the bubble/flush controls for those banks. Its sources are:
- load-use hazards;
- taken branches resolved in EX;
- data-memory wait states;
- HLT drain.

It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush/halt sequencer.
package pipe_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    // Number of bubble cycles needed to empty ID..WB after HLT leaves ID
    localparam int unsigned        DRAIN_W      = 2;
    localparam logic [DRAIN_W-1:0] DRAIN_CYCLES = 2'd3;

    // Default register-specifier width
    localparam int unsigned REG_W_DEFAULT = 4;

    // Bundle of bank controls, MSB first as listed
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
    } ctrl_t;

    // Canonical control patterns
    localparam ctrl_t CTRL_RUN    = 7'b1111100; // everything advances
    localparam ctrl_t CTRL_FLUSH  = 7'b1111111; // advance, squash IF/ID and ID/EX
    localparam ctrl_t CTRL_STALL  = 7'b0011101; // hold PC and IF/ID, bubble into EX
    localparam ctrl_t CTRL_FREEZE = 7'b0000000; // whole pipe frozen

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Enable-and-saturate up counter; sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count enabled cycles, stop at the ceiling instead of wrapping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/halt sequencer for the five-stage pipeline.
// Bank controls are combinational from state and hazard inputs; the
// halted flag and the stall-cycle counter are registered.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEFAULT,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_hlt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_br_taken,
    input  logic             dmem_req,
    input  logic             dmem_rdy,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t             r_state;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic               r_halted;

    state_t             w_state_nxt;
    logic [DRAIN_W-1:0] w_drain_nxt;
    ctrl_t              w_ctrl;
    logic               w_load_use;
    logic               w_freeze;
    logic               w_stall_en;

    // Load-use compare: register 0 is deliberately not special-cased
    always_comb begin
        w_load_use = ex_is_load &
                     ((id_rs_used & (id_rs == ex_rd)) |
                      (id_rt_used & (id_rt == ex_rd)));
    end

    // Priority decode of bank controls and next state
    always_comb begin
        w_ctrl      = CTRL_RUN;
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_freeze    = 1'b0;
        unique case (r_state)
            RUN, MEM_WAIT: begin
                // Once waiting, only dmem_rdy releases the freeze
                w_freeze = (r_state == MEM_WAIT) ? !dmem_rdy
                                                 : (dmem_req && !dmem_rdy);
                if (w_freeze) begin
                    w_ctrl      = CTRL_FREEZE;
                    w_state_nxt = MEM_WAIT;
                end else if (ex_br_taken) begin
                    w_ctrl      = CTRL_FLUSH;
                    w_state_nxt = RUN;
                end else if (w_load_use) begin
                    w_ctrl      = CTRL_STALL;
                    w_state_nxt = RUN;
                end else if (id_hlt && (r_state == RUN)) begin
                    w_ctrl      = CTRL_STALL;
                    w_state_nxt = DRAIN;
                    w_drain_nxt = DRAIN_CYCLES;
                end else begin
                    w_ctrl      = CTRL_RUN;
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                // Only bubbles and older instructions remain: branch and
                // load-use inputs are irrelevant here
                w_freeze = dmem_req && !dmem_rdy;
                if (w_freeze) begin
                    w_ctrl = CTRL_FREEZE;
                end else begin
                    w_ctrl      = CTRL_STALL;
                    w_drain_nxt = r_drain_cnt - 1'b1;
                    if (r_drain_cnt == 2'd1) begin
                        w_state_nxt = HALTED;
                    end
                end
            end
            HALTED: begin
                w_ctrl = CTRL_FREEZE;
            end
            default: begin
                w_ctrl      = CTRL_RUN;
                w_state_nxt = RUN;
            end
        endcase
    end

    // State, drain counter and halted flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_halted    <= (w_state_nxt == HALTED);
        end
    end

    // Count cycles the front end is held, excluding the final halt
    always_comb begin
        w_stall_en = !w_ctrl.pc_we && (r_state != HALTED);
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (w_stall_en),
        .o_count (stall_cnt)
    );

    assign pc_we       = w_ctrl.pc_we;
    assign if_id_we    = w_ctrl.if_id_we;
    assign id_ex_we    = w_ctrl.id_ex_we;
    assign ex_mem_we   = w_ctrl.ex_mem_we;
    assign mem_wb_we   = w_ctrl.mem_wb_we;
    assign if_id_flush = w_ctrl.if_id_flush;
    assign id_ex_flush = w_ctrl.id_ex_flush;
    assign halted      = r_halted;

endmodule
